// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of an N_IN-input combinational FUT, captures its truth table and
// compares it with an expected mask. A sweep takes 2^N_IN*(SETTLE+1) cycles, and done pulses one cycle later.
// start is taken only in IDLE and is never queued. Optional zero counter: `define ZERO_COUNT_EN.
// 'table' is a reserved word in Verilog, so the captured table is exported as truth_table.

module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_in,
    input  logic [2**N_IN-1:0]    expected,
    output logic [N_IN-1:0]       vec,
    output logic                  busy,
    output logic                  done,
    output logic [2**N_IN-1:0]    truth_table,
    output logic                  mismatch
`ifdef ZERO_COUNT_EN
    ,
    output logic [N_IN:0]         zero_cnt
`endif
);

    localparam int              NVEC        = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX    = '1;
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [N_IN-1:0]   idx_q,      idx_d;
    logic [7:0]        settle_q,   settle_d;
    logic [NVEC-1:0]   table_q,    table_d;
    logic              mismatch_q, mismatch_d;
`ifdef ZERO_COUNT_EN
    logic [N_IN:0]     zero_q,     zero_d;
`endif

    // State, sweep index, settle counter and result registers; reset aborts any sweep at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            settle_q   <= '0;
            table_q    <= '0;
            mismatch_q <= 1'b0;
`ifdef ZERO_COUNT_EN
            zero_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            table_q    <= table_d;
            mismatch_q <= mismatch_d;
`ifdef ZERO_COUNT_EN
            zero_q     <= zero_d;
`endif
        end
    end

    // Next-state and datapath updates; every register holds unless its state touches it.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        table_d    = table_q;
        mismatch_d = mismatch_q;
`ifdef ZERO_COUNT_EN
        zero_d     = zero_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // Results from the previous sweep are kept until a new sweep is accepted.
                if (start) begin
                    table_d    = '0;
                    mismatch_d = 1'b0;
                    idx_d      = '0;
                    settle_d   = '0;
`ifdef ZERO_COUNT_EN
                    zero_d     = '0;
`endif
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Hold the vector for exactly SETTLE cycles so the FUT output can settle.
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_SAMPLE: begin
                // s_in is stored unmodified, so an unknown FUT output stays visible in the table.
                table_d[idx_q] = s_in;
`ifdef ZERO_COUNT_EN
                if (s_in == 1'b0) begin
                    zero_d = zero_q + (N_IN+1)'(1);
                end
`endif
                // The last vector ends the sweep rather than wrapping the index.
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + N_IN'(1);
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                // The table is complete here, so the comparison sees every sampled bit.
                mismatch_d = (table_q != expected);
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state: vec is parked at 0 outside a sweep.
    always_comb begin
        vec  = '0;
        busy = 1'b0;
        done = 1'b0;
        if (state_q == S_DRIVE || state_q == S_SAMPLE) begin
            vec  = idx_q;
            busy = 1'b1;
        end
        if (state_q == S_DONE) begin
            done = 1'b1;
        end
    end

    assign truth_table = table_q;
    assign mismatch    = mismatch_q;
`ifdef ZERO_COUNT_EN
    assign zero_cnt    = zero_q;
`endif

endmodule
